// File: rtl/load_store_buffer_pkg.sv
// Shared constants for the load/store buffer: default sizing, funct3 codes, FSM states.
package load_store_buffer_pkg;

  localparam int LSB_SIZE     = 8;
  localparam int LSB_ID_WIDTH = $clog2(LSB_SIZE);

  // funct3 encodings for loads and stores
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Memory access sequencer: DRAIN swallows a flushed load still in flight
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } lsb_state_e;

endpackage

// File: rtl/load_store_buffer_load_ext.sv
// lsb_load_ext: extends raw memory data to a full register value according to funct3.
module lsb_load_ext
  import load_store_buffer_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   funct3,
  input  logic [W-1:0] raw,
  output logic [W-1:0] ext
);

  // B/H sign-extend, BU/HU zero-extend, W passes through
  always_comb begin
    ext = raw;
    case (funct3)
      LB:      ext = {{(W-8){raw[7]}}, raw[7:0]};
      LH:      ext = {{(W-16){raw[15]}}, raw[15:0]};
      LBU:     ext = {{(W-8){1'b0}}, raw[7:0]};
      LHU:     ext = {{(W-16){1'b0}}, raw[15:0]};
      LW:      ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order queue of memory ops. Operands are captured at issue and
// completed by CDB snooping; the oldest entry is sent to memory, one access at a time.
// Stores go out only after ROB commit. Optional macro LSB_IO_ORDER_EN holds IO-space
// loads (addr[17:16]==2'b11) until they are the oldest op in the ROB.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int LSB_SIZE   = load_store_buffer_pkg::LSB_SIZE,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int VAL_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic                  issue_store,
  input  logic [2:0]            issue_funct3,
  input  logic [ID_WIDTH-1:0]   issue_rob_id,
  input  logic [31:0]           issue_imm,
  input  logic                  base_rdy,
  input  logic [ID_WIDTH-1:0]   base_lab,
  input  logic [VAL_WIDTH-1:0]  base_val,
  input  logic                  data_rdy,
  input  logic [ID_WIDTH-1:0]   data_lab,
  input  logic [VAL_WIDTH-1:0]  data_val,
  input  logic                  cdb_valid,
  input  logic [ID_WIDTH-1:0]   cdb_lab,
  input  logic [VAL_WIDTH-1:0]  cdb_val,
  input  logic                  commit_valid,
  input  logic [ID_WIDTH-1:0]   rob2lsb_lab,
  input  logic [ID_WIDTH-1:0]   rob_head_id,
  output logic                  lsb_full,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_len,
  output logic [VAL_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_done,
  input  logic [VAL_WIDTH-1:0]  mem_rdata,
  output logic                  ld_valid,
  output logic [ID_WIDTH-1:0]   ld_lab,
  output logic [VAL_WIDTH-1:0]  ld_val
);

  localparam int PTR_W = $clog2(LSB_SIZE);
  localparam int CNT_W = PTR_W + 1;

  logic [LSB_SIZE-1:0]                vld_q, vld_d, st_q, st_d, cmt_q, cmt_d;
  logic [LSB_SIZE-1:0]                brdy_q, brdy_d, drdy_q, drdy_d;
  logic [LSB_SIZE-1:0][2:0]           f3_q, f3_d;
  logic [LSB_SIZE-1:0][ID_WIDTH-1:0]  rid_q, rid_d, blab_q, blab_d, dlab_q, dlab_d;
  logic [LSB_SIZE-1:0][31:0]          imm_q, imm_d;
  logic [LSB_SIZE-1:0][VAL_WIDTH-1:0] bval_q, bval_d, dval_q, dval_d;
  logic [PTR_W-1:0]                   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                   count_q, count_d, ccnt_q, ccnt_d;
  lsb_state_e                         state_q, state_d;
  logic                               mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0]              mem_addr_q, mem_addr_d;
  logic [1:0]                         mem_len_q, mem_len_d;
  logic [VAL_WIDTH-1:0]               mem_wdata_q, mem_wdata_d;
  logic                               ld_valid_q, ld_valid_d;
  logic [ID_WIDTH-1:0]                ld_lab_q, ld_lab_d;
  logic [VAL_WIDTH-1:0]               ld_val_q, ld_val_d;

  logic                 enq, deq, can_start, io_ok;
  logic [VAL_WIDTH-1:0] head_addr, ext_val;

  assign lsb_full  = (count_q == CNT_W'(LSB_SIZE));
  assign head_addr = bval_q[head_q] + imm_q[head_q];

`ifdef LSB_IO_ORDER_EN
  assign io_ok = st_q[head_q] || (head_addr[17:16] != 2'b11) || (rob_head_id == rid_q[head_q]);
`else
  assign io_ok = 1'b1;
  logic unused_rob_head;
  assign unused_rob_head = ^rob_head_id;
`endif

  assign can_start = vld_q[head_q] && brdy_q[head_q] && io_ok &&
                     (!st_q[head_q] || (drdy_q[head_q] && cmt_q[head_q]));

  lsb_load_ext #(.W(VAL_WIDTH)) u_ext (
    .funct3 (f3_q[head_q]),
    .raw    (mem_rdata),
    .ext    (ext_val)
  );

  // Next state: snoop, commit, memory FSM, dequeue, enqueue, then flush overrides
  always_comb begin
    vld_d = vld_q; st_d = st_q; cmt_d = cmt_q; f3_d = f3_q; rid_d = rid_q; imm_d = imm_q;
    brdy_d = brdy_q; blab_d = blab_q; bval_d = bval_q;
    drdy_d = drdy_q; dlab_d = dlab_q; dval_d = dval_q;
    head_d = head_q; tail_d = tail_q; count_d = count_q; ccnt_d = ccnt_q; state_d = state_q;
    mem_req_d = mem_req_q; mem_wr_d = mem_wr_q; mem_addr_d = mem_addr_q;
    mem_len_d = mem_len_q; mem_wdata_d = mem_wdata_q;
    ld_valid_d = ld_valid_q; ld_lab_d = ld_lab_q; ld_val_d = ld_val_q;
    enq = 1'b0; deq = 1'b0;
    if (rdy_in) begin
      ld_valid_d = 1'b0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (vld_q[i] && cdb_valid) begin
          if (!brdy_q[i] && blab_q[i] == cdb_lab) begin brdy_d[i] = 1'b1; bval_d[i] = cdb_val; end
          if (!drdy_q[i] && dlab_q[i] == cdb_lab) begin drdy_d[i] = 1'b1; dval_d[i] = cdb_val; end
        end
        if (commit_valid && vld_q[i] && st_q[i] && !cmt_q[i] && rid_q[i] == rob2lsb_lab) begin
          cmt_d[i] = 1'b1;
          ccnt_d   = ccnt_q + CNT_W'(1);
        end
      end
      case (state_q)
        ST_IDLE: if (can_start && !flush && !ld_valid_q) begin
          mem_req_d   = 1'b1;
          mem_wr_d    = st_q[head_q];
          mem_addr_d  = head_addr[ADDR_WIDTH-1:0];
          mem_len_d   = f3_q[head_q][1:0];
          mem_wdata_d = st_q[head_q] ? dval_q[head_q] : '0;
          state_d     = ST_WAIT;
        end
        ST_WAIT: if (mem_done) begin
          deq = 1'b1;
          mem_req_d = 1'b0; mem_wr_d = 1'b0; mem_addr_d = '0; mem_len_d = '0; mem_wdata_d = '0;
          state_d = ST_IDLE;
          if (!st_q[head_q] && !flush) begin
            ld_valid_d = 1'b1; ld_lab_d = rid_q[head_q]; ld_val_d = ext_val;
          end
        end else if (flush && !st_q[head_q]) begin
          state_d = ST_DRAIN;
        end
        ST_DRAIN: if (mem_done) begin
          mem_req_d = 1'b0; mem_wr_d = 1'b0; mem_addr_d = '0; mem_len_d = '0; mem_wdata_d = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (deq) begin
        vld_d[head_q] = 1'b0;
        cmt_d[head_q] = 1'b0;
        head_d = head_q + PTR_W'(1);
        if (st_q[head_q]) ccnt_d = ccnt_d - CNT_W'(1);
      end
      enq = issue_valid && !lsb_full;
      if (enq) begin
        vld_d[tail_q]  = 1'b1;
        st_d[tail_q]   = issue_store;
        cmt_d[tail_q]  = 1'b0;
        f3_d[tail_q]   = issue_funct3;
        rid_d[tail_q]  = issue_rob_id;
        imm_d[tail_q]  = issue_imm;
        brdy_d[tail_q] = base_rdy || (cdb_valid && cdb_lab == base_lab);
        blab_d[tail_q] = base_lab;
        bval_d[tail_q] = base_rdy ? base_val : cdb_val;
        drdy_d[tail_q] = data_rdy || (cdb_valid && cdb_lab == data_lab);
        dlab_d[tail_q] = data_lab;
        dval_d[tail_q] = data_rdy ? data_val : cdb_val;
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      // Committed stores sit contiguously at the head, so only they survive a flush
      if (flush) begin
        for (int i = 0; i < LSB_SIZE; i++) vld_d[i] = vld_d[i] & st_d[i] & cmt_d[i];
        tail_d  = head_d + ccnt_d[PTR_W-1:0];
        count_d = ccnt_d;
      end
    end
  end

  // State registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      vld_q <= '0; st_q <= '0; cmt_q <= '0; f3_q <= '0; rid_q <= '0; imm_q <= '0;
      brdy_q <= '0; blab_q <= '0; bval_q <= '0; drdy_q <= '0; dlab_q <= '0; dval_q <= '0;
      head_q <= '0; tail_q <= '0; count_q <= '0; ccnt_q <= '0; state_q <= ST_IDLE;
      mem_req_q <= 1'b0; mem_wr_q <= 1'b0; mem_addr_q <= '0; mem_len_q <= '0; mem_wdata_q <= '0;
      ld_valid_q <= 1'b0; ld_lab_q <= '0; ld_val_q <= '0;
    end else begin
      vld_q <= vld_d; st_q <= st_d; cmt_q <= cmt_d; f3_q <= f3_d; rid_q <= rid_d; imm_q <= imm_d;
      brdy_q <= brdy_d; blab_q <= blab_d; bval_q <= bval_d;
      drdy_q <= drdy_d; dlab_q <= dlab_d; dval_q <= dval_d;
      head_q <= head_d; tail_q <= tail_d; count_q <= count_d; ccnt_q <= ccnt_d; state_q <= state_d;
      mem_req_q <= mem_req_d; mem_wr_q <= mem_wr_d; mem_addr_q <= mem_addr_d;
      mem_len_q <= mem_len_d; mem_wdata_q <= mem_wdata_d;
      ld_valid_q <= ld_valid_d; ld_lab_q <= ld_lab_d; ld_val_q <= ld_val_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_len   = mem_len_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_valid  = ld_valid_q;
  assign ld_lab    = ld_lab_q;
  assign ld_val    = ld_val_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// Scoreboard bench for load_store_buffer: expected memory requests and load results are
// queued at issue; a memory responder and a load monitor pop and compare them.
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  logic        clk, rst_in, rdy_in, flush;
  logic        issue_valid, issue_store;
  logic [2:0]  issue_funct3;
  logic [3:0]  issue_rob_id;
  logic [31:0] issue_imm;
  logic        base_rdy, data_rdy, cdb_valid, commit_valid;
  logic [3:0]  base_lab, data_lab, cdb_lab, rob2lsb_lab, rob_head_id;
  logic [31:0] base_val, data_val, cdb_val;
  logic        lsb_full, mem_req, mem_wr, mem_done, ld_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, ld_val;
  logic [1:0]  mem_len;
  logic [3:0]  ld_lab;

  load_store_buffer dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .issue_valid(issue_valid), .issue_store(issue_store), .issue_funct3(issue_funct3),
    .issue_rob_id(issue_rob_id), .issue_imm(issue_imm),
    .base_rdy(base_rdy), .base_lab(base_lab), .base_val(base_val),
    .data_rdy(data_rdy), .data_lab(data_lab), .data_val(data_val),
    .cdb_valid(cdb_valid), .cdb_lab(cdb_lab), .cdb_val(cdb_val),
    .commit_valid(commit_valid), .rob2lsb_lab(rob2lsb_lab), .rob_head_id(rob_head_id),
    .lsb_full(lsb_full), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_lab(ld_lab), .ld_val(ld_val)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
  } req_t;
  typedef struct {
    logic [3:0]  lab;
    logic [31:0] val;
  } ld_t;

  req_t exp_req[$];
  ld_t  exp_ld[$];
  int   n_chk = 0, n_pass = 0;
  logic resp_busy;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin #400000; $display("FAIL watchdog: simulation time limit"); $fatal(1); end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
  endtask

  task automatic push_req(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int dly);
    req_t r;
    r.wr = wr; r.addr = addr; r.len = len; r.wdata = wdata; r.rdata = rdata; r.dly = dly;
    exp_req.push_back(r);
  endtask

  task automatic push_ld(input logic [3:0] lab, input logic [31:0] val);
    ld_t e;
    e.lab = lab; e.val = val;
    exp_ld.push_back(e);
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [3:0] rid,
                       input logic [31:0] imm, input logic brdy, input logic [3:0] blab,
                       input logic [31:0] bval, input logic drdy, input logic [3:0] dlab,
                       input logic [31:0] dval);
    issue_valid = 1; issue_store = st; issue_funct3 = f3; issue_rob_id = rid; issue_imm = imm;
    base_rdy = brdy; base_lab = blab; base_val = bval;
    data_rdy = drdy; data_lab = dlab; data_val = dval;
    @(posedge clk); #1;
    issue_valid = 0;
  endtask

  // Ready load with expected request and result queued
  task automatic load(input logic [2:0] f3, input logic [3:0] rid, input logic [31:0] addr,
                      input logic [31:0] rdata, input logic [31:0] val, input int dly);
    push_req(1'b0, addr, f3[1:0], 32'h0, rdata, dly);
    push_ld(rid, val);
    issue(1'b0, f3, rid, 32'h0, 1'b1, 4'h0, addr, 1'b1, 4'h0, 32'h0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_req.size() != 0 || exp_ld.size() != 0 || resp_busy) && n < 300) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_drain"}, 32'(exp_req.size() + exp_ld.size()), 32'h0);
  endtask

  // Memory controller model: checks each request, holds it for dly cycles, then completes
  initial begin
    req_t r;
    mem_done = 0; mem_rdata = 0; resp_busy = 0;
    forever begin
      @(negedge clk);
      if (!rst_in && mem_req) begin
        resp_busy = 1;
        if (exp_req.size() == 0) begin
          chk("unexp_req", 32'h1, 32'h0);
          r.wr = 0; r.addr = 0; r.len = 0; r.wdata = 0; r.rdata = 0; r.dly = 0;
        end else begin
          r = exp_req.pop_front();
          chk("req_wr", 32'(mem_wr), 32'(r.wr));
          chk("req_addr", mem_addr, r.addr);
          chk("req_len", 32'(mem_len), 32'(r.len));
          chk("req_wdata", mem_wdata, r.wdata);
        end
        for (int k = 0; k < r.dly; k++) begin
          @(negedge clk);
          chk("req_hold", {mem_req, mem_addr[30:0]}, {1'b1, r.addr[30:0]});
        end
        mem_done = 1; mem_rdata = r.rdata;
        @(negedge clk);
        mem_done = 0; mem_rdata = 0;
        resp_busy = 0;
      end
    end
  end

  // Load result monitor
  always @(negedge clk) begin
    if (!rst_in && ld_valid) begin
      if (exp_ld.size() == 0) chk("unexp_ld", {28'h0, ld_lab}, 32'hFFFF_FFFF);
      else begin
        ld_t e;
        e = exp_ld.pop_front();
        chk("ld_lab", 32'(ld_lab), 32'(e.lab));
        chk("ld_val", ld_val, e.val);
      end
    end
  end

  initial begin
    int n;
    rst_in = 1; rdy_in = 1; flush = 0; issue_valid = 0; issue_store = 0; issue_funct3 = 0;
    issue_rob_id = 0; issue_imm = 0; base_rdy = 0; base_lab = 0; base_val = 0;
    data_rdy = 0; data_lab = 0; data_val = 0; cdb_valid = 0; cdb_lab = 0; cdb_val = 0;
    commit_valid = 0; rob2lsb_lab = 0; rob_head_id = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_full", 32'(lsb_full), 32'h0);
    chk("rst_ld_valid", 32'(ld_valid), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wr", 32'(mem_wr), 32'h0);
    rst_in = 0;
    @(posedge clk); #1;

    // Word load with base+imm
    push_req(1'b0, 32'h104, 2'd2, 32'h0, 32'hDEADBEEF, 2);
    push_ld(4'd1, 32'hDEADBEEF);
    issue(1'b0, LW, 4'd1, 32'h4, 1'b1, 4'h0, 32'h100, 1'b1, 4'h0, 32'h0);
    drain("lw");

    // Extension variants, back to back
    load(LB,  4'd2, 32'h200, 32'h0000_0080, 32'hFFFF_FF80, 0);
    load(LBU, 4'd3, 32'h201, 32'h0000_0080, 32'h0000_0080, 0);
    load(LH,  4'd4, 32'h202, 32'h0000_8001, 32'hFFFF_8001, 1);
    load(LHU, 4'd5, 32'h204, 32'h0000_8001, 32'h0000_8001, 0);
    drain("ext");

    // Base operand arrives later via CDB, and in the same cycle as issue
    push_req(1'b0, 32'h210, 2'd2, 32'h0, 32'h55, 0);
    push_ld(4'd6, 32'h55);
    issue(1'b0, LW, 4'd6, 32'h10, 1'b0, 4'd5, 32'h0, 1'b1, 4'h0, 32'h0);
    repeat (2) @(posedge clk); #1;
    cdb_valid = 1; cdb_lab = 4'd5; cdb_val = 32'h200;
    @(posedge clk); #1;
    cdb_valid = 0;
    push_req(1'b0, 32'h308, 2'd2, 32'h0, 32'h66, 0);
    push_ld(4'd7, 32'h66);
    cdb_valid = 1; cdb_lab = 4'd9; cdb_val = 32'h300;
    issue(1'b0, LW, 4'd7, 32'h8, 1'b0, 4'd9, 32'h0, 1'b1, 4'h0, 32'h0);
    cdb_valid = 0;
    drain("cdb");

    // Store waits for data and commit
    issue(1'b1, SW, 4'd6, 32'h0, 1'b1, 4'h0, 32'h40, 1'b0, 4'd3, 32'h0);
    cdb_valid = 1; cdb_lab = 4'd3; cdb_val = 32'h7;
    @(posedge clk); #1;
    cdb_valid = 0;
    repeat (5) @(posedge clk); #1;
    chk("sw_nocommit", 32'(mem_req), 32'h0);
    push_req(1'b1, 32'h40, 2'd2, 32'h7, 32'h0, 1);
    commit_valid = 1; rob2lsb_lab = 4'd6;
    @(posedge clk); #1;
    commit_valid = 0;
    drain("sw");

    // Fill to full, ignored issue while full, refill after one dequeue (tail wraps)
    for (int i = 0; i < 8; i++)
      load(LW, 4'(i), 32'h1000 + 32'(4 * i), 32'h11 * 32'(i), 32'h11 * 32'(i), (i == 0) ? 12 : 0);
    chk("full", 32'(lsb_full), 32'h1);
    issue(1'b0, LW, 4'd9, 32'h0, 1'b1, 4'h0, 32'h999, 1'b1, 4'h0, 32'h0);
    chk("full_ignored", 32'(lsb_full), 32'h1);
    n = 0;
    while (lsb_full && n < 60) begin @(posedge clk); #1; n++; end
    chk("full_drop", 32'(lsb_full), 32'h0);
    load(LW, 4'd8, 32'h2000, 32'hABCD, 32'hABCD, 0);
    chk("refull", 32'(lsb_full), 32'h1);
    drain("full");

    // Two committed stores + three loads, flush with second commit in the same cycle
    push_req(1'b1, 32'h600, 2'd2, 32'h1111_1111, 32'h0, 6);
    push_req(1'b1, 32'h604, 2'd2, 32'h2222_2222, 32'h0, 1);
    issue(1'b1, SW, 4'd1, 32'h0, 1'b1, 4'h0, 32'h600, 1'b1, 4'h0, 32'h1111_1111);
    issue(1'b1, SW, 4'd2, 32'h4, 1'b1, 4'h0, 32'h600, 1'b1, 4'h0, 32'h2222_2222);
    for (int i = 3; i < 6; i++)
      issue(1'b0, LW, 4'(i), 32'h0, 1'b1, 4'h0, 32'h700 + 32'(i), 1'b1, 4'h0, 32'h0);
    commit_valid = 1; rob2lsb_lab = 4'd1;
    @(posedge clk); #1;
    rob2lsb_lab = 4'd2; flush = 1;
    @(posedge clk); #1;
    commit_valid = 0; flush = 0;
    load(LW, 4'd7, 32'h800, 32'h77, 32'h77, 0);
    drain("flush_st");

    // Flush while a load is in flight: request held to completion, result dropped
    push_req(1'b0, 32'h500, 2'd2, 32'h0, 32'hBAD, 6);
    issue(1'b0, LW, 4'd11, 32'h0, 1'b1, 4'h0, 32'h500, 1'b1, 4'h0, 32'h0);
    n = 0;
    while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain_req_seen", 32'(mem_req), 32'h1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    drain("flush_ld");
    load(LW, 4'd12, 32'h504, 32'h1234, 32'h1234, 0);
    drain("after_flush");

    // IO-space load
    push_req(1'b0, 32'h30000, 2'd2, 32'h0, 32'h10, 0);
    push_ld(4'd10, 32'h10);
    issue(1'b0, LW, 4'd10, 32'h0, 1'b1, 4'h0, 32'h30000, 1'b1, 4'h0, 32'h0);
`ifdef LSB_IO_ORDER_EN
    repeat (5) @(posedge clk); #1;
    chk("io_stall", 32'(mem_req), 32'h0);
    rob_head_id = 4'd10;
`endif
    drain("io");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
